// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b: one full-subtractor cell plus a borrow flop, one bit per
// clock LSB first, with start/busy/done handshake and borrow/overflow/zero flags.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  always_comb begin
    d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Result flags are loaded only on the completion edge, straight from the
  // next-state values, so partial results never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_q      <= '0;
      br_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          br_q   <= br_d;
          res_q  <= res_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            diff       <= res_d;
            borrow_out <= br_d;
            overflow   <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
            zero       <= (res_d == '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboarded bench for serial_ripple_subtractor at WIDTH=4 and WIDTH=8,
// with an arithmetic reference model and a done-driven monitor.
module tb_serial_ripple_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       br;
    logic       ov;
    logic       z;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       busy4, done4, br4, ov4, z4;
  logic       busy8, done8, br8, ov8, z8;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t hold[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(br4),
    .overflow(ov4), .zero(z4)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(br8),
    .overflow(ov8), .zero(z8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input int av, input int bv);
    exp_t r;
    int m, h, sa, sb, sd, d;
    m  = 1 << w;
    h  = m / 2;
    d  = (av - bv + m) % m;
    sa = (av >= h) ? av - m : av;
    sb = (bv >= h) ? bv - m : bv;
    sd = sa - sb;
    r.diff = 8'(d);
    r.br   = (av < bv);
    r.ov   = (sd >= h) || (sd < -h);
    r.z    = (d == 0);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic mon(input int k, input logic dn, input logic [7:0] df,
                     input logic br, input logic ov, input logic z);
    exp_t e;
    int   w;
    w = (k == 0) ? 4 : 8;
    if (!rst_n) begin
      hold[k].diff = '0;
      hold[k].br   = 1'b0;
      hold[k].ov   = 1'b0;
      hold[k].z    = 1'b0;
      check($sformatf("w%0d_done_in_reset", w), 32'(dn), 32'd0);
    end else if (dn) begin
      if ((k == 0 && q4.size() == 0) || (k == 1 && q8.size() == 0)) begin
        n_checks++;
        n_err++;
        $display("FAIL w%0d_unexpected_done: got done=1 expected done=0 (t=%0t)", w, $time);
      end else begin
        if (k == 0) e = q4.pop_front();
        else        e = q8.pop_front();
        check($sformatf("w%0d_latency", w), 32'(cyc), 32'(e.cyc + w));
        hold[k] = e;
      end
    end
    check($sformatf("w%0d_diff", w), 32'(df), 32'(hold[k].diff));
    check($sformatf("w%0d_borrow", w), 32'(br), 32'(hold[k].br));
    check($sformatf("w%0d_overflow", w), 32'(ov), 32'(hold[k].ov));
    check($sformatf("w%0d_zero", w), 32'(z), 32'(hold[k].z));
  endtask

  always @(negedge clk) begin
    mon(0, done4, {4'b0, diff4}, br4, ov4, z4);
    mon(1, done8, diff8, br8, ov8, z8);
  end

  // Entered at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_op(input int w, input int av, input int bv, input bit hold_start,
                       output int dcyc);
    exp_t e;
    int   nb;
    bit   seen;
    logic dn, bs;
    e = model(w, av, bv);
    if (w == 4) begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
    else        begin a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1; end
    @(posedge clk);
    #1;
    e.cyc = cyc;
    if (w == 4) q4.push_back(e);
    else        q8.push_back(e);
    if (w == 4) begin a4 = 4'($urandom); b4 = 4'($urandom); start4 = hold_start; end
    else        begin a8 = 8'($urandom); b8 = 8'($urandom); start8 = hold_start; end
    nb   = 0;
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < w + 4 && !seen; i++) begin
      @(negedge clk);
      dn = (w == 4) ? done4 : done8;
      bs = (w == 4) ? busy4 : busy8;
      if (dn) begin
        seen = 1'b1;
        dcyc = cyc;
        check($sformatf("w%0d_busy_at_done", w), 32'(bs), 32'd0);
      end else if (bs) begin
        nb++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL w%0d_done_timeout: got no done within %0d cycles expected done after %0d", w, w + 4, w);
    end
    check($sformatf("w%0d_busy_cycles", w), 32'(nb), 32'(w));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running at %0t expected finish before 1000000", $time);
    $fatal(1);
  end

  initial begin
    int d1, d2, dd;
    int ba[5];
    int bb[5];
    rst_n  = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4, 9, 3, 1'b0, dd);
    do_op(4, 3, 9, 1'b0, dd);
    do_op(4, 5, 5, 1'b0, dd);
    do_op(4, 7, 8, 1'b0, dd);

    // start held high: next op is accepted on the first IDLE edge
    do_op(4, 12, 4, 1'b1, d1);
    do_op(4, 0, 1, 1'b1, d2);
    start4 = 1'b0;
    check("hold_start_spacing", 32'(d2 - d1), 32'd6);

    // asynchronous reset during the second SHIFT cycle
    a4 = 4'd15; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy4), 32'd0);
    check("async_rst_done", 32'(done4), 32'd0);
    check("async_rst_diff", 32'(diff4), 32'd0);
    check("async_rst_borrow", 32'(br4), 32'd0);
    check("async_rst_overflow", 32'(ov4), 32'd0);
    check("async_rst_zero", 32'(z4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(4, 15, 1, 1'b0, dd);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_op(4, x, y, 1'b0, dd);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    ba = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h00};
    bb = '{8'h01, 8'hFF, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 5; i++) do_op(8, ba[i], bb[i], 1'b0, dd);
    for (int i = 0; i < 60; i++) begin
      do_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, dd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
